// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a one-entry output register and redirect flush
// Optional macro FETCH_FAULT_EN adds alignment/bounds fault detection with a sticky fault flag.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef IMEM_DEPTH
`define IMEM_DEPTH 256
`endif

module fetch_unit #(
  parameter int          ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter int          WORD_WIDTH = `WORD_WIDTH,
  parameter int          MEM_SIZE   = `IMEM_DEPTH,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [WORD_WIDTH-1:0] imem_inst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_inst,
  output logic [31:0]           out_pc,
  output logic                  fault
);

  typedef enum logic [1:0] {S_WAIT, S_RUN, S_FAULT} state_t;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0] out_inst_q, out_inst_d;
  logic [31:0]           out_pc_q, out_pc_d;
  logic                  fault_q, fault_d;
  logic                  load_ok;
  logic                  load;
  logic                  bad_addr;

`ifdef FETCH_FAULT_EN
  localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);
  assign bad_addr = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= MEM_WORDS);
`else
  assign bad_addr = 1'b0;
`endif

  assign imem_addr = pc_q[ADDR_WIDTH+1:2];
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign fault     = fault_q;

  // A slot is available when the register is empty or being drained this cycle.
  assign load_ok = (state_q == S_RUN) && fetch_en && !redirect_valid &&
                   (!out_valid_q || out_ready);
  assign load    = load_ok && !bad_addr;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    fault_d     = fault_q;
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      state_d     = S_RUN;
      fault_d     = 1'b0;
    end else begin
      if (state_q == S_WAIT) begin
        state_d = S_RUN;
      end
      if (load) begin
        out_inst_d  = imem_inst;
        out_pc_d    = pc_q;
        out_valid_d = 1'b1;
        pc_d        = pc_q + 32'd4;
      end else begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
`ifdef FETCH_FAULT_EN
        if (load_ok) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized scoreboard bench for fetch_unit
module tb_fetch_unit;
  localparam int AW = 8;
  localparam int MS = 56;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_inst;
  logic          fetch_en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic          fault;

  logic [31:0] mem [256];
  logic [31:0] start_q [$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_acc  = 0;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  assign imem_inst = mem[imem_addr];

  fetch_unit #(.ADDR_WIDTH(AW), .WORD_WIDTH(32), .MEM_SIZE(MS), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .fault(fault)
  );

  // Instruction expected at a byte address: word index modulo the 256-word memory.
  function automatic logic [31:0] gold(input logic [31:0] pc);
    logic [31:0] w;
    w = (pc >> 2) % 32'd256;
    return mem[w[7:0]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_pc"}, out_pc, pc);
    chk({name, "_inst"}, out_inst, gold(pc));
  endtask

  // Monitor: accepted outputs must follow the sequential stream begun by the latest redirect.
  logic [31:0] exp_pc = 32'd0;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0, p_fen = 1'b1;
  logic [31:0] p_pc = 32'd0, p_inst = 32'd0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (p_redir) begin
        chk("bubble_after_redirect", {31'd0, out_valid}, 32'd0);
      end else if (p_valid && !p_ready) begin
        chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold_pc", out_pc, p_pc);
        chk("stall_hold_inst", out_inst, p_inst);
      end else if (!p_fen) begin
        chk("no_load_fetch_en_low", {31'd0, out_valid}, 32'd0);
      end
      if (redirect_valid) begin
        if (start_q.size() == 0) begin
          chk("start_queue_nonempty", 32'd0, 32'd1);
        end else begin
          exp_pc = start_q.pop_front();
        end
      end else if (out_valid && out_ready) begin
        chk("stream_pc", out_pc, exp_pc);
        chk("stream_inst", out_inst, gold(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
    end
    p_valid = out_valid;
    p_ready = out_ready;
    p_redir = redirect_valid;
    p_fen   = fetch_en;
    p_pc    = out_pc;
    p_inst  = out_inst;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);

    @(negedge clk); rst = 1'b0;
    tick(); chk("wait_no_fetch", {31'd0, out_valid}, 32'd0);
    tick(); chk_out("first_A", 32'h0);
    tick(); chk_out("second_B", 32'h4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("stall_B", 32'h4);
      chk("stall_pc8", {24'd0, imem_addr}, 32'd2);
    end
    out_ready = 1'b1;
    tick(); chk_out("third_C", 32'h8);
    out_ready = 1'b0;
    tick(); chk_out("stall_C", 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick(); chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_addr", {24'd0, imem_addr}, 32'h10);
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick(); chk_out("redir_40", 32'h40);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick(); chk("redir_wins_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_wins_addr", {24'd0, imem_addr}, 32'h20);
    redirect_valid = 1'b0;
    tick(); chk_out("redir_80", 32'h80);
    fetch_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); chk("fen_low_drain", {31'd0, out_valid}, 32'd0);
      chk("fen_low_pc", {24'd0, imem_addr}, 32'h21);
    end
    fetch_en = 1'b1;
`ifdef FETCH_FAULT_EN
    redirect_valid = 1'b1; redirect_pc = 32'hE0;
    tick(); redirect_valid = 1'b0;
    chk("oob_bubble", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); chk("oob_fault", {31'd0, fault}, 32'd1);
      chk("oob_no_load", {31'd0, out_valid}, 32'd0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick(); redirect_valid = 1'b0;
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    tick(); chk_out("after_fault_A", 32'h0);
`else
    redirect_valid = 1'b1; redirect_pc = 32'hE2;
    tick(); redirect_valid = 1'b0;
    chk("misalign_bubble", {31'd0, out_valid}, 32'd0);
    tick(); chk_out("misalign_E2", 32'hE2);
    chk("no_fault", {31'd0, fault}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect_valid = 1'b0;
    tick(); chk_out("top_of_space", 32'hFFFF_FFFC);
    chk("pc_wrap", {24'd0, imem_addr}, 32'd0);
`endif
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick(); redirect_valid = 1'b0;
    tick(); chk_out("pre_rst_hold", 32'h20);
    tick(); chk_out("pre_rst_hold2", 32'h20);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_addr", {24'd0, imem_addr}, 32'd0);
    chk("async_rst_pc", out_pc, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      tick();
      fetch_en  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      if (c == 0 || ($urandom % 20) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'($urandom_range(0, MS - 1)) << 2;
        start_q.push_back(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
      if (c == 0) mon_en = 1'b1;
    end
    tick(); redirect_valid = 1'b0;
    repeat (4) tick();
    mon_en = 1'b0;
    chk("enough_accepts", {31'd0, n_acc > 200}, 32'd1);
    chk("start_queue_drained", start_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `MEM_ADDR_WIDTH, instruction-memory word-address width.
REQ-002 SHALL have parameter WORD_WIDTH, default `WORD_WIDTH, instruction width.
REQ-003 SHALL have parameter MEM_SIZE, default `IMEM_DEPTH, number of instruction words.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, byte PC after reset.
REQ-005 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have imem_addr  output  ADDR_WIDTH  word address to instruction memory, = pc[ADDR_WIDTH+1:2].
REQ-008 SHALL have imem_inst  input  WORD_WIDTH  instruction returned combinationally for imem_addr.
REQ-009 SHALL have fetch_en  input  1  permit new fetches.
REQ-010 SHALL have redirect_valid  input  1  branch/jump redirect request.
REQ-011 SHALL have redirect_pc  input  32  redirect target byte address.
REQ-012 SHALL have out_valid  output  1  out_inst/out_pc hold a valid instruction.
REQ-013 SHALL have out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-014 SHALL have out_inst  output  WORD_WIDTH  fetched instruction.
REQ-015 SHALL have out_pc  output  32  byte address of out_inst.
REQ-016 SHALL have fault  output  1  sticky fetch fault flag.

Function
REQ-017 SHALL hold a 32-bit byte PC register pc; state machine states WAIT, RUN, FAULT.
REQ-018 SHALL go WAIT -> RUN on first clock edge after reset release; no fetch in WAIT.
REQ-019 SHALL define load = (state==RUN) && fetch_en && !redirect_valid && (!out_valid || out_ready).
REQ-020 SHALL on load: out_inst<=imem_inst, out_pc<=pc, out_valid<=1, pc<=pc+4 (modulo 2^32, wraps FFFF_FFFC -> 0).
REQ-021 SHALL on out_valid && out_ready && !load: out_valid<=0.
REQ-022 SHALL hold out_valid, out_inst, out_pc, pc unchanged while out_valid && !out_ready (stall).
REQ-023 SHALL on redirect_valid: pc<=redirect_pc, out_valid<=0 (flush, even if held/unaccepted), from any state; priority over load and stall.
REQ-024 SHALL first present redirect target with out_valid=1 two edges after redirect asserted (one bubble cycle).
REQ-025 SHALL with fetch_en low: no loads, held output still drains via handshake, pc unchanged.
REQ-026 SHALL drive imem_addr from pc every cycle regardless of state.

Reset
REQ-027 SHALL on rst asynchronously set pc=RESET_PC, out_valid=0, out_inst=0, out_pc=0, fault=0, state=WAIT.
REQ-028 SHALL discard any held instruction when rst asserts mid-stall.

Configuration
REQ-029 SHALL with FETCH_FAULT_EN defined: a would-be load where pc[1:0]!=0 or pc[31:2]>=MEM_SIZE does not load, sets fault=1, state<=FAULT; FAULT performs no loads; redirect_valid clears fault and returns to RUN; held output drains normally.
REQ-030 SHALL without FETCH_FAULT_EN: fault tied 0, pc[1:0] ignored, address truncated to ADDR_WIDTH bits (wraps within memory), FAULT state unreachable.

Verification
REQ-031 SHALL test reset release, out_ready=1, fetch_en=1, mem[0..2]=A,B,C -> out_valid first high after second edge, outputs (0,A),(4,B),(8,C) on consecutive cycles.
REQ-032 SHALL test out_ready=0 for 3 cycles holding (4,B) -> out_inst/out_pc stable, pc stays 8, then (8,C) cycle after out_ready=1.
REQ-033 SHALL test redirect_valid with redirect_pc=0x40 while (8,C) stalled -> out_valid=0 next cycle, then (0x40,mem[16]).
REQ-034 SHALL test simultaneous redirect_valid and out_ready with load eligible -> redirect wins, no pc+4 increment.
REQ-035 SHALL test with FETCH_FAULT_EN, MEM_SIZE=56, redirect to 0xE0 -> fault=1, out_valid=0, no loads; redirect to 0x0 -> fault=0, (0,A).
REQ-036 SHALL test rst asserted mid-stall -> out_valid=0, pc=RESET_PC immediately, without waiting for clock edge.
